// File: rtl/puc_sequencer_if.sv
// Instruction-memory and datapath bus between the PUC sequencer (master)
// and the memory/accumulator side (slave).
interface puc_sequencer_if #(
    parameter int COUNTER_WIDTH     = 4,
    parameter int INSTRUCTION_WIDTH = 11
);
    logic [COUNTER_WIDTH-1:0]     count;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [7:0]                   operand;
    logic                         loadi_en;
    logic                         move_en;
    logic                         add_en;
    logic                         dp_ready;
    logic                         restart;

    modport master (
        output count, operand, loadi_en, move_en, add_en, restart,
        input  instruction, dp_ready
    );

    modport slave (
        input  count, operand, loadi_en, move_en, add_en, restart,
        output instruction, dp_ready
    );
endinterface

// File: rtl/puc_sequencer.sv
// PUC CPU fetch/execute controller: pc, instruction register, execute strobes.
// Define PUC_SEQ_STEP_EN to enable single-step requests from the debug port.
module puc_sequencer #(
    parameter int          COUNTER_WIDTH     = 4,
    parameter int          INSTRUCTION_WIDTH = 11,
    parameter int          START_ADDR        = 1,
    parameter logic [2:0]  OP_NOP            = 3'd0,
    parameter logic [2:0]  OP_LOADI          = 3'd1,
    parameter logic [2:0]  OP_MOVE           = 3'd2,
    parameter logic [2:0]  OP_ADD            = 3'd3,
    parameter logic [2:0]  OP_RESET          = 3'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    output logic              busy,
    output logic              illegal,
    puc_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t                       state;
    logic [COUNTER_WIDTH-1:0]     pc;
    logic [INSTRUCTION_WIDTH-1:0] ir;
    logic                         loadi_en;
    logic                         move_en;
    logic                         add_en;
    logic                         restart;
    logic                         stall;
    logic [2:0]                   ir_op;
    logic [2:0]                   mem_op;

    assign ir_op  = ir[INSTRUCTION_WIDTH-1 -: 3];
    assign mem_op = bus.instruction[INSTRUCTION_WIDTH-1 -: 3];
    assign stall  = (loadi_en | move_en | add_en) & ~bus.dp_ready;

    assign bus.count    = pc;
    assign bus.operand  = ir[7:0];
    assign bus.loadi_en = loadi_en;
    assign bus.move_en  = move_en;
    assign bus.add_en   = add_en;
    assign bus.restart  = restart;

`ifdef PUC_SEQ_STEP_EN
    logic step_req;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= COUNTER_WIDTH'(START_ADDR);
            ir       <= '0;
            loadi_en <= 1'b0;
            move_en  <= 1'b0;
            add_en   <= 1'b0;
            restart  <= 1'b0;
            busy     <= 1'b0;
            illegal  <= 1'b0;
`ifdef PUC_SEQ_STEP_EN
            step_req <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef PUC_SEQ_STEP_EN
                    if (run || step) begin
                        step_req <= ~run;
                        state    <= FETCH;
                        busy     <= 1'b1;
                    end
`else
                    if (run) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
`endif
                end
                FETCH: begin
                    // Strobes are decoded from memory here so they are registered on EXEC entry
                    ir       <= bus.instruction;
                    state    <= EXEC;
                    loadi_en <= (mem_op == OP_LOADI);
                    move_en  <= (mem_op == OP_MOVE);
                    add_en   <= (mem_op == OP_ADD);
                    restart  <= (mem_op == OP_RESET);
                end
                EXEC: begin
                    if (!stall) begin
                        loadi_en <= 1'b0;
                        move_en  <= 1'b0;
                        add_en   <= 1'b0;
                        restart  <= 1'b0;
                        case (ir_op)
                            OP_NOP, OP_LOADI, OP_MOVE, OP_ADD: pc <= pc + 1'b1;
                            OP_RESET: pc <= COUNTER_WIDTH'(START_ADDR);
                            default: begin
                                pc      <= pc + 1'b1;
                                illegal <= 1'b1;
                            end
                        endcase
`ifdef PUC_SEQ_STEP_EN
                        if (run && !step_req) begin
                            state <= FETCH;
                        end else begin
                            step_req <= 1'b0;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
`else
                        if (run) begin
                            state <= FETCH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_puc_sequencer.sv
// Bench for puc_sequencer: per-cycle vector table, directed corner sequences,
// and randomized programs checked against an instruction-level model.
module tb_puc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        dp_ready;
    logic        busy;
    logic        illegal;
    logic [10:0] mem [16];

    int errors = 0;
    int checks = 0;

    puc_sequencer_if #(.COUNTER_WIDTH(4), .INSTRUCTION_WIDTH(11)) bus ();

    assign bus.instruction = mem[bus.count];
    assign bus.dp_ready    = dp_ready;

    puc_sequencer #(
        .COUNTER_WIDTH(4),
        .INSTRUCTION_WIDTH(11),
        .START_ADDR(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .step(step),
        .busy(busy),
        .illegal(illegal),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        dp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_program();
        for (int unsigned i = 0; i < 16; i++) mem[i] = 11'h000;
        mem[1] = {3'd1, 8'd3};
        mem[2] = {3'd2, 8'd0};
        mem[3] = {3'd1, 8'd1};
        mem[4] = {3'd3, 8'd0};
        mem[5] = {3'd4, 8'd0};
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    typedef struct {
        int run, dp, cnt, l, m, a, r, b, op;
    } vec_t;
    vec_t vecs[25];

    typedef struct {
        int kind, op, addr, ill;
    } ev_t;
    ev_t expq[$];

    initial begin
        logic [16:0] act, exp;
        int          seen, cnt_strobe, nev, kind;
        logic [2:0]  opc;
        logic [10:0] w;
        int          mpc, mill;
        ev_t         e;

        vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 1, 1, 0, 0, 0, 1, 3};
        vecs[2]  = '{1, 1, 2, 0, 0, 0, 0, 1, 3};
        vecs[3]  = '{1, 1, 2, 0, 1, 0, 0, 1, 0};
        vecs[4]  = '{1, 1, 3, 0, 0, 0, 0, 1, 0};
        vecs[5]  = '{1, 1, 3, 1, 0, 0, 0, 1, 1};
        vecs[6]  = '{1, 1, 4, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{1, 1, 4, 0, 0, 1, 0, 1, 0};
        vecs[8]  = '{1, 1, 5, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{1, 1, 5, 0, 0, 0, 1, 1, 0};
        vecs[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 0};
        vecs[11] = '{1, 1, 1, 1, 0, 0, 0, 1, 3};
        vecs[12] = '{1, 1, 2, 0, 0, 0, 0, 1, 3};
        vecs[13] = '{1, 1, 2, 0, 1, 0, 0, 1, 0};
        vecs[14] = '{1, 1, 3, 0, 0, 0, 0, 1, 0};
        vecs[15] = '{1, 1, 3, 1, 0, 0, 0, 1, 1};
        vecs[16] = '{1, 1, 4, 0, 0, 0, 0, 1, 1};
        vecs[17] = '{1, 1, 4, 0, 0, 1, 0, 1, 0};
        vecs[18] = '{1, 0, 4, 0, 0, 1, 0, 1, 0};
        vecs[19] = '{1, 0, 4, 0, 0, 1, 0, 1, 0};
        vecs[20] = '{1, 0, 4, 0, 0, 1, 0, 1, 0};
        vecs[21] = '{1, 1, 5, 0, 0, 0, 0, 1, 0};
        vecs[22] = '{0, 1, 5, 0, 0, 0, 1, 1, 0};
        vecs[23] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[24] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};

        // Reset state, sampled while rst_n is held low
        load_program();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; dp_ready = 1'b1;
        @(posedge clk);
        #1;
        act = {bus.count, bus.loadi_en, bus.move_en, bus.add_en, bus.restart, busy, bus.operand};
        check("reset_outputs", 32'(act), 32'({4'd1, 5'b0, 8'd0}));
        check("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Program run with stall during ADD and run dropped during RESET
        for (int unsigned i = 0; i < 25; i++) begin
            run      = 1'(vecs[i].run);
            dp_ready = 1'(vecs[i].dp);
            @(posedge clk);
            #1;
            act = {bus.count, bus.loadi_en, bus.move_en, bus.add_en, bus.restart, busy, bus.operand};
            exp = {4'(vecs[i].cnt), 1'(vecs[i].l), 1'(vecs[i].m), 1'(vecs[i].a),
                   1'(vecs[i].r), 1'(vecs[i].b), 8'(vecs[i].op)};
            check($sformatf("vec%0d", i), 32'(act), 32'(exp));
        end

        // Single-step from the debug port
        do_reset();
`ifdef PUC_SEQ_STEP_EN
        pulse_step();
        repeat (4) @(posedge clk);
        #1;
        check("step1_count", 32'(bus.count), 32'd2);
        check("step1_busy", 32'(busy), 32'd0);
        pulse_step();
        cnt_strobe = 0;
        seen = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            if (bus.move_en) seen++;
            if (bus.loadi_en || bus.add_en || bus.restart) cnt_strobe++;
            @(posedge clk);
            #1;
        end
        check("step2_move_cycles", 32'(seen), 32'd1);
        check("step2_other_strobes", 32'(cnt_strobe), 32'd0);
        check("step2_count", 32'(bus.count), 32'd3);
        check("step2_busy", 32'(busy), 32'd0);
`else
        pulse_step();
        seen = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            if (busy || bus.loadi_en || bus.move_en || bus.add_en || bus.restart) seen++;
            @(posedge clk);
            #1;
        end
        check("step_ignored_activity", 32'(seen), 32'd0);
        check("step_ignored_count", 32'(bus.count), 32'd1);
`endif

        // run and step together, run dropped in EXEC
        do_reset();
        run = 1'b1;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        seen = 0;
        for (int unsigned c = 0; c < 6 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en) seen = 1;
        end
        check("runstep_first_strobe", 32'(seen), 32'd1);
        run = 1'b0;
        cnt_strobe = 1;
        for (int unsigned c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en || bus.move_en || bus.add_en || bus.restart) cnt_strobe++;
        end
        check("runstep_strobe_cycles", 32'(cnt_strobe), 32'd1);
        check("runstep_count", 32'(bus.count), 32'd2);
        check("runstep_busy", 32'(busy), 32'd0);

        // pc wrap 15 -> 0 -> 1 with an illegal opcode at address 0
        do_reset();
        for (int unsigned i = 0; i < 16; i++) mem[i] = 11'h000;
        mem[0] = {3'd6, 8'hAA};
        run = 1'b1;
        seen = 0;
        cnt_strobe = 0;
        for (int unsigned c = 0; c < 60 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en || bus.move_en || bus.add_en || bus.restart) cnt_strobe++;
            if (bus.count == 4'd15) seen = 1;
        end
        check("wrap_reached_15", 32'(seen), 32'd1);
        check("wrap_illegal_before", 32'(illegal), 32'd0);
        for (int unsigned c = 0; c < 5 && bus.count == 4'd15; c++) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en || bus.move_en || bus.add_en || bus.restart) cnt_strobe++;
        end
        check("wrap_to_0", 32'(bus.count), 32'd0);
        for (int unsigned c = 0; c < 5 && bus.count == 4'd0; c++) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en || bus.move_en || bus.add_en || bus.restart) cnt_strobe++;
        end
        check("wrap_to_1", 32'(bus.count), 32'd1);
        check("wrap_illegal_set", 32'(illegal), 32'd1);
        run = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.loadi_en || bus.move_en || bus.add_en || bus.restart) cnt_strobe++;
        end
        check("wrap_no_strobes", 32'(cnt_strobe), 32'd0);
        check("wrap_illegal_sticky", 32'(illegal), 32'd1);
        check("wrap_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a stalled ADD
        do_reset();
        mem[1] = {3'd3, 8'h55};
        run = 1'b1;
        dp_ready = 1'b0;
        seen = 0;
        for (int unsigned c = 0; c < 6 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.add_en) seen = 1;
        end
        check("arst_add_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_add_dropped", 32'(bus.add_en), 32'd0);
        check("arst_busy_dropped", 32'(busy), 32'd0);
        check("arst_restart_low", 32'(bus.restart), 32'd0);
        @(posedge clk);
        #1;
        run = 1'b0;
        dp_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_count_after", 32'(bus.count), 32'd1);
        check("arst_idle_after", 32'(busy), 32'd0);

        // Randomized programs against an instruction-level model
        do_reset();
        for (int unsigned i = 0; i < 16; i++) mem[i] = {3'($urandom_range(0, 7)), 8'($urandom)};
        mem[1] = {3'd1, 8'($urandom)};
        expq.delete();
        mpc = 1;
        mill = 0;
        for (int unsigned n = 0; n < 300; n++) begin
            w = mem[mpc];
            opc = w[10:8];
            if (opc >= 3'd1 && opc <= 3'd4) expq.push_back('{int'(opc), int'(w[7:0]), mpc, mill});
            if (opc == 3'd4) mpc = 1;
            else mpc = (mpc + 1) % 16;
            if (opc >= 3'd5) mill = 1;
        end
        run = 1'b1;
        nev = 0;
        for (int unsigned c = 0; c < 400; c++) begin
            @(posedge clk);
            #1 dp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rand_onehot", 32'($countones({bus.loadi_en, bus.move_en, bus.add_en, bus.restart}) <= 1), 32'd1);
            kind = bus.loadi_en ? 1 : bus.move_en ? 2 : bus.add_en ? 3 : bus.restart ? 4 : 0;
            if ((kind >= 1 && kind <= 3 && dp_ready) || kind == 4) begin
                if (expq.size() == 0) begin
                    check("rand_unexpected_event", 32'(kind), 32'd0);
                end else begin
                    e = expq.pop_front();
                    nev++;
                    check("rand_kind", 32'(kind), 32'(e.kind));
                    check("rand_operand", 32'(bus.operand), 32'(e.op));
                    check("rand_addr", 32'(bus.count), 32'(e.addr));
                    check("rand_illegal", 32'(illegal), 32'(e.ill));
                end
            end
        end
        check("rand_enough_events", 32'(nev > 20), 32'd1);
        run = 1'b0;
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/puc_sequencer.md
# puc_sequencer

Fetch/execute controller for the PUC CPU. Owns the program counter that addresses the combinational instruction memory, latches each fetched instruction into an instruction register, and issues one-hot execute strobes with an 8-bit operand to the accumulator datapath. Handles the RESET opcode as a jump back to the program start, a datapath ready handshake, and run/single-step control from the debug port.

## Interface
- COUNTER_WIDTH, 4, program counter / memory address width
- INSTRUCTION_WIDTH, 11, instruction width: opcode in [10:8], operand in [7:0]
- START_ADDR, 1, first program address after reset and after a RESET opcode
- OP_NOP, 3'd0, opcode encoding
- OP_LOADI, 3'd1, opcode encoding
- OP_MOVE, 3'd2, opcode encoding
- OP_ADD, 3'd3, opcode encoding
- OP_RESET, 3'd4, opcode encoding

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; continuous execution while high
- step  in  1  one-cycle pulse; executes exactly one instruction while run is low
- count  out  COUNTER_WIDTH  memory address, registered (equals pc)
- instruction  in  INSTRUCTION_WIDTH  memory read data, combinational from count
- operand  out  8  operand field of the instruction register
- loadi_en, move_en, add_en  out  1 each  execute strobes, mutually exclusive
- dp_ready  in  1  datapath accepts the current strobe this cycle
- restart  out  1  one-cycle pulse when a RESET opcode executes
- busy  out  1  high in FETCH and EXEC
- illegal  out  1  sticky; set by any opcode 5–7

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: strobes low, busy low. Goes to FETCH if run=1, or if step=1 (step latched as a one-instruction request). If run and step are both high, run wins and the step request is not latched.
- FETCH: count=pc. At the clock edge ending FETCH, ir <= instruction, and the state goes to EXEC.
- EXEC, by opcode in ir:
  - LOADI, MOVE, ADD: assert the matching strobe, with operand=ir[7:0]. Hold while dp_ready=0. On the edge where dp_ready=1: pc <= pc+1, and the strobe drops on the next cycle.
  - RESET: restart=1 for the single EXEC cycle. pc <= START_ADDR. dp_ready is ignored.
  - NOP: no strobe, pc <= pc+1, dp_ready is ignored.
  - 5–7: handled as NOP, and illegal <= 1.
- After EXEC completes: go to FETCH if run=1 and no step request is pending. Otherwise clear the step request and go to IDLE.
- Deasserting run mid-instruction does not abort. The current instruction completes, then the state goes to IDLE.
- pc increment is modulo 2^COUNTER_WIDTH: 15 wraps to 0. Address 0 is executed normally.
- illegal clears only on rst_n.

## Timing
- Reset values: state=IDLE, pc=count=START_ADDR, ir=0, operand=0, all strobes 0, restart=0, busy=0, illegal=0. Reset takes effect immediately, including mid-EXEC with a strobe asserted.
- With dp_ready=1 held, each instruction takes 2 cycles (FETCH, EXEC). Strobes are high for exactly one cycle. count advances on the edge closing EXEC.
- With dp_ready low for N cycles, EXEC lasts N+1 cycles and the strobe is held throughout.
- From run rising in IDLE, the first strobe appears 2 cycles later: IDLE sampled, then FETCH, then EXEC.
- Strobes, operand and restart are registered outputs with no combinational paths from inputs.

## Configuration
- PUC_SEQ_STEP_EN defined: step behaves as described above.
- PUC_SEQ_STEP_EN undefined: step is ignored and no step-request register exists. The block leaves IDLE only on run=1 and returns to IDLE only when run=0 at the end of EXEC.

## Test plan
- Program {1:LOADI 3, 2:MOVE 0, 3:LOADI 1, 4:ADD 0, 5:RESET}, with run=1 and dp_ready=1:
  - required strobe sequence: loadi(3), move, loadi(1), add, then restart.
  - count then returns to 1, and the sequence repeats with a 10-cycle period.
- dp_ready held low for 3 cycles during ADD → add_en high for 4 cycles, count stays at 4, then moves to 5.
- run=0 and a step pulse at count=2 → exactly one move_en, count=3, returns to IDLE with busy=0. Without PUC_SEQ_STEP_EN: no activity.
- pc=15 holding a NOP, with run=1 → count goes 15→0→1. Opcode 6 at address 0 → illegal=1, no strobe, and illegal stays set.
- rst_n asserted mid-EXEC with add_en high → add_en, busy and restart drop immediately, and count=1 in IDLE after release.
- run and step asserted in the same cycle, then run dropped during EXEC → the current instruction completes, the block goes to IDLE, and no extra step instruction executes.
